// File: rtl/ms_arbiter_if.sv
// rtl/ms_arbiter_if.sv - requester, store and status signals of the main-store arbiter
interface ms_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              req_cu;
  logic              we_cu;
  logic [ADDR_W-1:0] addr_cu;
  logic [DATA_W-1:0] wdata_cu;
  logic              gnt_cu;
  logic              ack_cu;
  logic [DATA_W-1:0] rdata_cu;

  logic              req_ext;
  logic              we_ext;
  logic [ADDR_W-1:0] addr_ext;
  logic [DATA_W-1:0] wdata_ext;
  logic              gnt_ext;
  logic              ack_ext;
  logic [DATA_W-1:0] rdata_ext;

  logic [ADDR_W-1:0] ms_addr;
  logic              ms_read;
  logic              ms_write;
  logic [DATA_W-1:0] ms_wdata;
  logic [DATA_W-1:0] ms_rdata;
  logic              busy;

  modport slave (
    input  req_cu, we_cu, addr_cu, wdata_cu,
    input  req_ext, we_ext, addr_ext, wdata_ext,
    input  ms_rdata,
    output gnt_cu, ack_cu, rdata_cu,
    output gnt_ext, ack_ext, rdata_ext,
    output ms_addr, ms_read, ms_write, ms_wdata, busy
  );

  modport master (
    output req_cu, we_cu, addr_cu, wdata_cu,
    output req_ext, we_ext, addr_ext, wdata_ext,
    output ms_rdata,
    input  gnt_cu, ack_cu, rdata_cu,
    input  gnt_ext, ack_ext, rdata_ext,
    input  ms_addr, ms_read, ms_write, ms_wdata, busy
  );
endinterface

// File: rtl/ms_arbiter.sv
// rtl/ms_arbiter.sv - two-requester round-robin arbiter for a single-port main store
module ms_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  ms_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_ACC  = 3'd2,
    S_CAPT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              owner_ext_q, owner_ext_d;
  logic              last_ext_q, last_ext_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_cu_q, rdata_cu_d;
  logic [DATA_W-1:0] rdata_ext_q, rdata_ext_d;
  logic              pick_ext;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_ext_q <= 1'b0;
      last_ext_q  <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_cu_q  <= '0;
      rdata_ext_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_ext_q <= owner_ext_d;
      last_ext_q  <= last_ext_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_cu_q  <= rdata_cu_d;
      rdata_ext_q <= rdata_ext_d;
    end
  end

  // On a tie the requester not served last wins; a lone requester always wins.
  always_comb begin
    pick_ext = bus.req_ext && (!bus.req_cu || !last_ext_q);
  end

  always_comb begin
    state_d     = state_q;
    owner_ext_d = owner_ext_q;
    last_ext_d  = last_ext_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_cu_d  = rdata_cu_q;
    rdata_ext_d = rdata_ext_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_cu || bus.req_ext) begin
          state_d     = S_ADDR;
          owner_ext_d = pick_ext;
          last_ext_d  = pick_ext;
          we_d        = pick_ext ? bus.we_ext    : bus.we_cu;
          addr_d      = pick_ext ? bus.addr_ext  : bus.addr_cu;
          wdata_d     = pick_ext ? bus.wdata_ext : bus.wdata_cu;
        end
      end
      S_ADDR: state_d = S_ACC;
      S_ACC:  state_d = S_CAPT;
      S_CAPT: begin
        state_d = S_DONE;
        // Store data is valid the cycle after the read strobe.
        if (!we_q) begin
          if (owner_ext_q) rdata_ext_d = bus.ms_rdata;
          else             rdata_cu_d  = bus.ms_rdata;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.gnt_cu    = bus.busy && !owner_ext_q;
  assign bus.gnt_ext   = bus.busy &&  owner_ext_q;
  assign bus.ack_cu    = (state_q == S_DONE) && !owner_ext_q;
  assign bus.ack_ext   = (state_q == S_DONE) &&  owner_ext_q;
  assign bus.ms_read   = (state_q == S_ACC) && !we_q;
  assign bus.ms_write  = (state_q == S_ACC) &&  we_q;
  assign bus.ms_addr   = addr_q;
  assign bus.ms_wdata  = wdata_q;
  assign bus.rdata_cu  = rdata_cu_q;
  assign bus.rdata_ext = rdata_ext_q;

endmodule

// File: tb/tb_ms_arbiter.sv
// tb/tb_ms_arbiter.sv - scoreboard bench for ms_arbiter with a transaction-level reference model
module tb_ms_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ms_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  ms_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int            cyc;
    bit            ext;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd_cu;
    logic [DW-1:0] rd_ext;
  } exp_t;

  // Power-up store contents; address 3 holds A5.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return DW'(32'hA5 + (int'(a) - 3) * 29);
  endfunction

  // Physical store behind the arbiter
  logic [DW-1:0] st_mem [32];
  bit            st_wr  [32];
  always @(posedge clk) begin
    if (bus.ms_write) begin
      st_mem[bus.ms_addr] <= bus.ms_wdata;
      st_wr[bus.ms_addr]  <= 1'b1;
    end
    if (bus.ms_read)
      bus.ms_rdata <= st_wr[bus.ms_addr] ? st_mem[bus.ms_addr] : init_val(bus.ms_addr);
  end

  // Reference model: each accepted request occupies the store for five cycles
  exp_t          exp_q [256];
  int            wr_n = 0;
  int            cyc = 0;
  int            m_count = 0;
  bit            m_owner_ext = 0;
  bit            m_last_ext = 1;
  bit            m_rst_seen = 1;
  logic [DW-1:0] m_rd_cu = '0;
  logic [DW-1:0] m_rd_ext = '0;
  logic [DW-1:0] m_mem [32];
  bit            m_wr  [32];
  exp_t          ent;
  bit            win_ext;

  always @(posedge clk) begin
    cyc = cyc + 1;
    m_rst_seen = !rst;
    if (!rst) begin
      m_count = 0; m_last_ext = 1; m_owner_ext = 0; m_rd_cu = '0; m_rd_ext = '0;
    end else if (m_count > 0) begin
      m_count = m_count - 1;
    end else if (bus.req_cu || bus.req_ext) begin
      if (bus.req_cu && bus.req_ext) win_ext = !m_last_ext;
      else                           win_ext = bus.req_ext;
      m_last_ext  = win_ext;
      m_owner_ext = win_ext;
      m_count     = 4;
      ent.cyc   = cyc;
      ent.ext   = win_ext;
      ent.we    = win_ext ? bus.we_ext    : bus.we_cu;
      ent.addr  = win_ext ? bus.addr_ext  : bus.addr_cu;
      ent.wdata = win_ext ? bus.wdata_ext : bus.wdata_cu;
      if (ent.we) begin
        m_mem[ent.addr] = ent.wdata;
        m_wr[ent.addr]  = 1'b1;
      end else if (win_ext) begin
        m_rd_ext = m_wr[ent.addr] ? m_mem[ent.addr] : init_val(ent.addr);
      end else begin
        m_rd_cu = m_wr[ent.addr] ? m_mem[ent.addr] : init_val(ent.addr);
      end
      ent.rd_cu  = m_rd_cu;
      ent.rd_ext = m_rd_ext;
      exp_q[wr_n % 256] = ent;
      wr_n = wr_n + 1;
    end
  end

  // Monitor / scoreboard
  int   n_chk = 0;
  int   n_fail = 0;
  int   st_rd = 0;
  int   ak_rd = 0;
  int   wait_cu = 0;
  int   wait_ext = 0;
  int   tmo_cnt = 0;
  bit   end_req = 0;
  bit   end_done = 0;
  exp_t e;
  bit   exp_busy;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk = n_chk + 1;
    if (!ok) begin
      n_fail = n_fail + 1;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (m_rst_seen) begin
      chk({bus.busy, bus.gnt_cu, bus.gnt_ext, bus.ack_cu, bus.ack_ext, bus.ms_read, bus.ms_write} == 7'b0,
          "reset_ctrl", {bus.busy, bus.gnt_cu, bus.gnt_ext, bus.ack_cu, bus.ack_ext, bus.ms_read, bus.ms_write}, 0);
      chk({bus.ms_addr, bus.ms_wdata, bus.rdata_cu, bus.rdata_ext} == '0, "reset_data",
          {bus.ms_addr, bus.ms_wdata, bus.rdata_cu, bus.rdata_ext}, 0);
    end else begin
      exp_busy = (m_count > 0);
      chk({bus.busy, bus.gnt_cu, bus.gnt_ext} == {exp_busy, exp_busy && !m_owner_ext, exp_busy && m_owner_ext},
          "busy_gnt", {bus.busy, bus.gnt_cu, bus.gnt_ext}, {exp_busy, exp_busy && !m_owner_ext, exp_busy && m_owner_ext});

      if (bus.ms_read || bus.ms_write) begin
        if (st_rd >= wr_n) begin
          chk(1'b0, "unexpected_strobe", {bus.ms_read, bus.ms_write}, 0);
        end else begin
          e = exp_q[st_rd % 256];
          st_rd = st_rd + 1;
          chk(cyc == e.cyc + 1, "strobe_cycle", cyc, e.cyc + 1);
          chk({bus.ms_read, bus.ms_write} == {!e.we, e.we}, "strobe_type", {bus.ms_read, bus.ms_write}, {!e.we, e.we});
          chk(bus.ms_addr == e.addr, "ms_addr", bus.ms_addr, e.addr);
          if (e.we) chk(bus.ms_wdata == e.wdata, "ms_wdata", bus.ms_wdata, e.wdata);
        end
      end else if (st_rd < wr_n && cyc > exp_q[st_rd % 256].cyc + 1) begin
        chk(1'b0, "missing_strobe", cyc, exp_q[st_rd % 256].cyc + 1);
        st_rd = st_rd + 1;
      end

      if (bus.ack_cu || bus.ack_ext) begin
        if (ak_rd >= wr_n) begin
          chk(1'b0, "unexpected_ack", {bus.ack_cu, bus.ack_ext}, 0);
        end else begin
          e = exp_q[ak_rd % 256];
          ak_rd = ak_rd + 1;
          chk(cyc == e.cyc + 3, "ack_cycle", cyc, e.cyc + 3);
          chk({bus.ack_cu, bus.ack_ext} == {!e.ext, e.ext}, "ack_owner", {bus.ack_cu, bus.ack_ext}, {!e.ext, e.ext});
          chk(bus.rdata_cu == e.rd_cu, "rdata_cu", bus.rdata_cu, e.rd_cu);
          chk(bus.rdata_ext == e.rd_ext, "rdata_ext", bus.rdata_ext, e.rd_ext);
        end
      end else if (ak_rd < wr_n && cyc > exp_q[ak_rd % 256].cyc + 3) begin
        chk(1'b0, "missing_ack", cyc, exp_q[ak_rd % 256].cyc + 3);
        ak_rd = ak_rd + 1;
      end
    end

    // Starvation bound for continuously asserted requests
    if (!rst) begin
      wait_cu = 0; wait_ext = 0;
    end else begin
      if (bus.req_cu && !bus.gnt_cu) wait_cu = wait_cu + 1;
      else begin
        if (bus.gnt_cu && wait_cu > 0) chk(wait_cu <= 10, "starve_cu", wait_cu, 10);
        wait_cu = 0;
      end
      if (bus.req_ext && !bus.gnt_ext) wait_ext = wait_ext + 1;
      else begin
        if (bus.gnt_ext && wait_ext > 0) chk(wait_ext <= 10, "starve_ext", wait_ext, 10);
        wait_ext = 0;
      end
    end

    if (!rst) begin
      st_rd = wr_n;
      ak_rd = wr_n;
    end

    if (end_req && !end_done) begin
      chk(ak_rd == wr_n, "acks_outstanding", wr_n - ak_rd, 0);
      chk(st_rd == wr_n, "strobes_outstanding", wr_n - st_rd, 0);
      chk(tmo_cnt == 0, "handshake_timeouts", tmo_cnt, 0);
      end_done = 1;
    end
  end

  // Stimulus
  task automatic drive_cu(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_cu = r; bus.we_cu = w; bus.addr_cu = a; bus.wdata_cu = d;
  endtask

  task automatic drive_ext(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_ext = r; bus.we_ext = w; bus.addr_ext = a; bus.wdata_ext = d;
  endtask

  // Issue one access, drop the request and scramble its fields right after grant.
  task automatic do_op(input bit ext, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got;
    @(posedge clk); #2;
    if (ext) drive_ext(1'b1, w, a, d); else drive_cu(1'b1, w, a, d);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #2;
      got = ext ? bus.gnt_ext : bus.gnt_cu;
    end
    if (!got) tmo_cnt = tmo_cnt + 1;
    if (ext) drive_ext(1'b0, !w, a + 5'd1, ~d); else drive_cu(1'b0, !w, a + 5'd1, ~d);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #2;
      got = ext ? bus.ack_ext : bus.ack_cu;
    end
    if (!got) tmo_cnt = tmo_cnt + 1;
  endtask

  initial begin
    drive_cu(1'b0, 1'b0, '0, '0);
    drive_ext(1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    do_op(1'b0, 1'b0, 5'h03, 8'h00);
    do_op(1'b1, 1'b1, 5'h1F, 8'h3C);
    do_op(1'b0, 1'b1, 5'h01, 8'h5E);
    do_op(1'b0, 1'b0, 5'h01, 8'h00);
    do_op(1'b1, 1'b0, 5'h1F, 8'h00);
    do_op(1'b1, 1'b0, 5'h00, 8'h00);

    // Both requesting from reset: CU must win the first tie
    @(posedge clk); #2 rst = 1'b0;
    drive_cu(1'b1, 1'b0, 5'h07, 8'h11);
    drive_ext(1'b1, 1'b1, 5'h08, 8'h22);
    @(posedge clk); #2 rst = 1'b1;
    repeat (22) @(posedge clk);
    #2;
    drive_cu(1'b0, 1'b0, '0, '0);
    drive_ext(1'b0, 1'b0, '0, '0);
    repeat (6) @(posedge clk);

    // Reset during the store cycle of a write
    #2 drive_ext(1'b1, 1'b1, 5'h0A, 8'h77);
    @(posedge clk); #2 drive_ext(1'b0, 1'b0, '0, '0);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    do_op(1'b1, 1'b0, 5'h0A, 8'h00);
    do_op(1'b0, 1'b0, 5'h0A, 8'h00);

    // Sustained external traffic while the CU requests once
    @(posedge clk); #2 drive_ext(1'b1, 1'b0, 5'h12, 8'h00);
    repeat (3) @(posedge clk);
    #2 drive_cu(1'b1, 1'b0, 5'h13, 8'h00);
    for (int i = 0; i < 20 && !bus.gnt_cu; i++) begin
      @(posedge clk); #2;
    end
    if (!bus.gnt_cu) tmo_cnt = tmo_cnt + 1;
    drive_cu(1'b0, 1'b0, '0, '0);
    repeat (12) @(posedge clk);
    #2 drive_ext(1'b0, 1'b0, '0, '0);
    repeat (6) @(posedge clk);

    // Randomised traffic with fields changing every cycle
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #2;
      drive_cu($urandom_range(0, 99) < 40, 1'($urandom), AW'($urandom), DW'($urandom));
      drive_ext($urandom_range(0, 99) < 40, 1'($urandom), AW'($urandom), DW'($urandom));
    end
    @(posedge clk); #2;
    drive_cu(1'b0, 1'b0, '0, '0);
    drive_ext(1'b0, 1'b0, '0, '0);
    repeat (12) @(posedge clk);

    end_req = 1;
    for (int i = 0; i < 5 && !end_done; i++) @(posedge clk);
    if (!end_done) begin
      $display("FAIL end_handshake: monitor did not complete final checks");
      $fatal(1, "monitor stalled");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
